// File: rtl/qenc_pkg.sv
// -----------------------------------------------------------------------------
// qenc_pkg
// Shared definitions for the quadrature encoder peripheral:
//   - register address map of the read-only bus slave
//   - status register bit positions
//   - velocity saturation limits
//   - quadrature step classification helpers
// Build option: QENC_VELOCITY_EN enables the velocity measurement logic in
// quad_encoder_velocity; this package is the same in both builds.
// -----------------------------------------------------------------------------
package qenc_pkg;

    localparam logic [15:0] QENC_ADDR_POS_LSB = 16'h0001;
    localparam logic [15:0] QENC_ADDR_POS_MSB = 16'h0002;
    localparam logic [15:0] QENC_ADDR_STATUS  = 16'h0003;
    localparam logic [15:0] QENC_ADDR_VEL     = 16'h0004;

    localparam int QENC_STAT_DIR    = 0;
    localparam int QENC_STAT_ERR    = 1;
    localparam int QENC_STAT_SYNC_B = 2;
    localparam int QENC_STAT_SYNC_A = 3;
    localparam int QENC_STAT_MOVING = 4;

    localparam int QENC_VEL_MAX = 127;
    localparam int QENC_VEL_MIN = -128;

    typedef enum logic [1:0] {
        QSTEP_HOLD    = 2'd0,
        QSTEP_INC     = 2'd1,
        QSTEP_DEC     = 2'd2,
        QSTEP_ILLEGAL = 2'd3
    } qenc_step_e;

    // Position of an {A,B} pair along the clockwise cycle 00->01->11->10.
    function automatic logic [1:0] qenc_phase(input logic [1:0] ab);
        logic [1:0] ph;
        case (ab)
            2'b00:   ph = 2'd0;
            2'b01:   ph = 2'd1;
            2'b11:   ph = 2'd2;
            default: ph = 2'd3;
        endcase
        return ph;
    endfunction

    // Phase difference modulo 4: +1 is one CW step, -1 (3) one CCW step,
    // 2 means both channels changed at once.
    function automatic qenc_step_e qenc_classify(input logic [1:0] prev_ab,
                                                 input logic [1:0] cur_ab);
        logic [1:0] diff;
        qenc_step_e step;
        diff = qenc_phase(cur_ab) - qenc_phase(prev_ab);
        case (diff)
            2'd1:    step = QSTEP_INC;
            2'd3:    step = QSTEP_DEC;
            2'd2:    step = QSTEP_ILLEGAL;
            default: step = QSTEP_HOLD;
        endcase
        return step;
    endfunction

    // Clamp a window count into the signed 8-bit velocity register range.
    function automatic logic [7:0] qenc_saturate(input logic signed [31:0] v);
        logic [7:0] r;
        if (v > QENC_VEL_MAX) begin
            r = 8'h7F;
        end else if (v < QENC_VEL_MIN) begin
            r = 8'h80;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/qenc_decoder.sv
// -----------------------------------------------------------------------------
// qenc_decoder
// Two-flop synchronizers for encoder channels A and B followed by x4
// quadrature transition decoding against the previous synchronized state.
// Ports:
//   clk, rst_n     - system clock, asynchronous active-low reset
//   a, b           - raw encoder channels (asynchronous to clk)
//   inc, dec       - one-cycle pulse per valid CW / CCW transition
//   illegal        - one-cycle pulse when both channels changed together
//   sync_a, sync_b - synchronized channel levels
// -----------------------------------------------------------------------------
module qenc_decoder
    import qenc_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    input  logic b,
    output logic inc,
    output logic dec,
    output logic illegal,
    output logic sync_a,
    output logic sync_b
);

    logic [1:0] meta_ab;
    logic [1:0] sync_ab;
    logic [1:0] prev_ab;
    qenc_step_e step;

    // prev_ab trails sync_ab by one cycle, so each transition is seen once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_ab <= 2'b00;
            sync_ab <= 2'b00;
            prev_ab <= 2'b00;
        end else begin
            meta_ab <= {a, b};
            sync_ab <= meta_ab;
            prev_ab <= sync_ab;
        end
    end

    always_comb begin
        step    = qenc_classify(prev_ab, sync_ab);
        inc     = (step == QSTEP_INC);
        dec     = (step == QSTEP_DEC);
        illegal = (step == QSTEP_ILLEGAL);
    end

    assign sync_a = sync_ab[1];
    assign sync_b = sync_ab[0];

endmodule

// File: rtl/quad_encoder_velocity.sv
// -----------------------------------------------------------------------------
// quad_encoder_velocity
// Read-only 8-bit bus peripheral for a quadrature encoder: 16-bit wrapping
// position counter, direction and sticky error flags and, optionally, a
// windowed velocity measurement.
// Build option: define QENC_VELOCITY_EN to include the velocity window
// counter, accumulator, velocity register (0x0004) and status bit4 (moving).
// Without it 0x0004 reads 0x00, status bit4 is 0 and VEL_WINDOW is unused.
// Ports:
//   clk, rst_n   - system clock, asynchronous active-low reset
//   addr         - register address
//   cs, rd       - chip select and read strobe
//   data_out     - read data (0x00 unless cs && rd)
//   A, B         - raw encoder channels
// Register map: 0x0001 pos[7:0] (also latches pos[15:8] into the MSB
// shadow), 0x0002 MSB shadow, 0x0003 status, 0x0004 velocity.
// -----------------------------------------------------------------------------
module quad_encoder_velocity
    import qenc_pkg::*;
#(
    parameter int VEL_WINDOW = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    output logic [7:0]  data_out,
    input  logic        cs,
    input  logic        rd,
    input  logic        A,
    input  logic        B
);

    logic        inc;
    logic        dec;
    logic        illegal;
    logic        sync_a;
    logic        sync_b;
    logic [15:0] position;
    logic [7:0]  pos_msb_shadow;
    logic        dir;
    logic        err;
    logic        lsb_read;
    logic        status_read;
    logic        moving;
    logic [7:0]  vel_reg_value;
    logic [7:0]  status;

    qenc_decoder u_decoder (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (A),
        .b       (B),
        .inc     (inc),
        .dec     (dec),
        .illegal (illegal),
        .sync_a  (sync_a),
        .sync_b  (sync_b)
    );

    assign lsb_read    = cs && rd && (addr == QENC_ADDR_POS_LSB);
    assign status_read = cs && rd && (addr == QENC_ADDR_STATUS);

    // An illegal transition wins over a clearing status read so no error is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            position       <= 16'h0000;
            pos_msb_shadow <= 8'h00;
            dir            <= 1'b0;
            err            <= 1'b0;
        end else begin
            if (inc) begin
                position <= position + 16'd1;
                dir      <= 1'b1;
            end else if (dec) begin
                position <= position - 16'd1;
                dir      <= 1'b0;
            end
            if (illegal) begin
                err <= 1'b1;
            end else if (status_read) begin
                err <= 1'b0;
            end
            if (lsb_read) begin
                pos_msb_shadow <= position[15:8];
            end
        end
    end

`ifdef QENC_VELOCITY_EN
    localparam logic [31:0] WIN_LAST = 32'(VEL_WINDOW - 1);

    logic [31:0]        win_cnt;
    logic signed [31:0] vel_acc;
    logic signed [31:0] step_delta;
    logic [7:0]         velocity;

    assign step_delta = inc ? 32'sd1 : (dec ? -32'sd1 : 32'sd0);

    // The final cycle's transition is folded into the value loaded at window end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt  <= 32'd0;
            vel_acc  <= 32'sd0;
            velocity <= 8'h00;
        end else if (win_cnt == WIN_LAST) begin
            win_cnt  <= 32'd0;
            vel_acc  <= 32'sd0;
            velocity <= qenc_saturate(vel_acc + step_delta);
        end else begin
            win_cnt  <= win_cnt + 32'd1;
            vel_acc  <= vel_acc + step_delta;
        end
    end

    assign moving        = (velocity != 8'h00);
    assign vel_reg_value = velocity;
`else
    logic unused_vel_window;

    assign unused_vel_window = (VEL_WINDOW > 0);
    assign moving            = 1'b0;
    assign vel_reg_value     = 8'h00;
`endif

    always_comb begin
        status                   = 8'h00;
        status[QENC_STAT_DIR]    = dir;
        status[QENC_STAT_ERR]    = err;
        status[QENC_STAT_SYNC_B] = sync_b;
        status[QENC_STAT_SYNC_A] = sync_a;
        status[QENC_STAT_MOVING] = moving;
    end

    always_comb begin
        data_out = 8'h00;
        if (cs && rd) begin
            case (addr)
                QENC_ADDR_POS_LSB: data_out = position[7:0];
                QENC_ADDR_POS_MSB: data_out = pos_msb_shadow;
                QENC_ADDR_STATUS:  data_out = status;
                QENC_ADDR_VEL:     data_out = vel_reg_value;
                default:           data_out = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_quad_encoder_velocity.sv
// -----------------------------------------------------------------------------
// tb_quad_encoder_velocity
// Self-checking bench for quad_encoder_velocity. A behavioural model tracks
// the encoder as a position on the CW sequence 00->01->11->10 and predicts
// position, direction, error flag, shadow and status. Velocity cases are
// included when QENC_VELOCITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_quad_encoder_velocity;

    localparam int VEL_WINDOW = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr;
    logic [7:0]  data_out;
    logic        cs;
    logic        rd;
    logic        A;
    logic        B;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [1:0] cw_next [4];
    int         model_pos;
    bit         model_dir;
    bit         model_err;
    logic [1:0] model_ab;
    int         model_shadow;

    always #5 clk = ~clk;

    quad_encoder_velocity #(.VEL_WINDOW(VEL_WINDOW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .data_out (data_out),
        .cs       (cs),
        .rd       (rd),
        .A        (A),
        .B        (B)
    );

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            $error("[TB] FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        model_pos    = 0;
        model_dir    = 1'b0;
        model_err    = 1'b0;
        model_ab     = 2'b00;
        model_shadow = 0;
    endtask

    task automatic model_step(input logic [1:0] nab);
        if (nab == model_ab) begin
            // no movement
        end else if (cw_next[model_ab] == nab) begin
            model_pos = (model_pos + 1) & 16'hFFFF;
            model_dir = 1'b1;
        end else if (cw_next[nab] == model_ab) begin
            model_pos = (model_pos + 16'hFFFF) & 16'hFFFF;
            model_dir = 1'b0;
        end else begin
            model_err = 1'b1;
        end
        model_ab = nab;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        A     = 1'b0;
        B     = 1'b0;
        cs    = 1'b0;
        rd    = 1'b0;
        addr  = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Drives new channel levels and waits until they have reached the counters.
    task automatic apply_ab(input logic [1:0] nab);
        @(negedge clk);
        {A, B} = nab;
        model_step(nab);
        repeat (3) @(negedge clk);
    endtask

    function automatic logic [1:0] ccw_of(input logic [1:0] ab);
        logic [1:0] r;
        r = ab;
        for (int s = 0; s < 4; s++) begin
            if (cw_next[s] == ab) r = 2'(s);
        end
        return r;
    endfunction

    task automatic step_cw();
        apply_ab(cw_next[model_ab]);
    endtask

    task automatic step_ccw();
        apply_ab(ccw_of(model_ab));
    endtask

    // Holds the select across one rising edge so shadow capture and err
    // clearing take effect, mirrored in the model.
    task automatic read_reg(input logic [15:0] a, output logic [7:0] v);
        @(negedge clk);
        addr = a;
        cs   = 1'b1;
        rd   = 1'b1;
        #1 v = data_out;
        @(negedge clk);
        cs = 1'b0;
        rd = 1'b0;
        if (a == 16'h0001) model_shadow = (model_pos >> 8) & 8'hFF;
        if (a == 16'h0003) model_err = 1'b0;
    endtask

    function automatic logic [7:0] model_status();
        return {3'b000, 1'b0, model_ab[1], model_ab[0], model_err, model_dir};
    endfunction

    task automatic expect_state(input string tag);
        logic [7:0] v;
        logic [7:0] exp_status;
        logic [7:0] mask;
`ifdef QENC_VELOCITY_EN
        mask = 8'hEF;
`else
        mask = 8'hFF;
`endif
        read_reg(16'h0001, v);
        check_output({tag, "_lsb"}, v, 8'(model_pos & 8'hFF));
        read_reg(16'h0002, v);
        check_output({tag, "_msb"}, v, 8'(model_shadow));
        exp_status = model_status();
        read_reg(16'h0003, v);
        check_output({tag, "_status"}, v & mask, exp_status & mask);
    endtask

    initial begin
        logic [7:0] v;
        int         r;

        cw_next[0] = 2'b01;
        cw_next[1] = 2'b11;
        cw_next[3] = 2'b10;
        cw_next[2] = 2'b00;

        // Reset state of every register plus an unmapped address
        do_reset();
        for (int a = 1; a <= 5; a++) begin
            read_reg(16'(a), v);
            check_output($sformatf("reset_reg%0d", a), v, 8'h00);
        end
        @(negedge clk);
        #1 check_output("idle_bus", data_out, 8'h00);

        // Four CW steps: one full cycle
        for (int i = 0; i < 4; i++) step_cw();
        expect_state("cw4");

        // One CCW step from reset, checking the input latency on the way
        do_reset();
        @(negedge clk);
        {A, B} = 2'b10;
        @(negedge clk);
        @(negedge clk);
        addr = 16'h0001;
        cs   = 1'b1;
        rd   = 1'b1;
        #1 check_output("latency_before", data_out, 8'h00);
        @(negedge clk);
        #1 check_output("latency_after", data_out, 8'hFF);
        cs = 1'b0;
        rd = 1'b0;
        model_step(2'b10);
        expect_state("ccw1");
        step_cw();
        expect_state("ccw_then_cw");

        // Illegal jump 00->11, then err clears after one status read
        apply_ab(2'b11);
        expect_state("illegal");
        read_reg(16'h0003, v);
        check_output("err_cleared", v & 8'h02, 8'h00);

        // MSB shadow coherence across a carry into the upper byte
        do_reset();
        for (int i = 0; i < 255; i++) step_cw();
        read_reg(16'h0001, v);
        check_output("shadow_lsb", v, 8'hFF);
        step_cw();
        read_reg(16'h0002, v);
        check_output("shadow_msb", v, 8'h00);
        expect_state("shadow_after");

        // Reset in the middle of operation clears state immediately
        step_cw();
        step_cw();
        @(negedge clk);
        rst_n = 1'b0;
        A     = 1'b0;
        B     = 1'b0;
        addr  = 16'h0001;
        cs    = 1'b1;
        rd    = 1'b1;
        #1 check_output("midreset_lsb", data_out, 8'h00);
        addr = 16'h0003;
        #1 check_output("midreset_status", data_out, 8'h00);
        cs = 1'b0;
        rd = 1'b0;
        do_reset();

        // Random walk against the model
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4) begin
                step_cw();
            end else if (r < 8) begin
                step_ccw();
            end else if (r == 8) begin
                apply_ab(model_ab);
            end else begin
                apply_ab(~model_ab);
            end
            expect_state($sformatf("rand%0d", i));
        end

`ifdef QENC_VELOCITY_EN
        // 10 CW steps per window, then the same rate CCW
        do_reset();
        for (int i = 0; i < 30; i++) begin
            step_cw();
            repeat (96) @(negedge clk);
        end
        read_reg(16'h0004, v);
        check_output("vel_cw", v, 8'h0A);
        read_reg(16'h0003, v);
        check_output("vel_moving", v & 8'h10, 8'h10);
        for (int i = 0; i < 30; i++) begin
            step_ccw();
            repeat (96) @(negedge clk);
        end
        read_reg(16'h0004, v);
        check_output("vel_ccw", v, 8'hF6);

        // 200 steps inside the first window saturate both ways
        do_reset();
        for (int i = 0; i < 200; i++) step_cw();
        repeat (400) @(negedge clk);
        read_reg(16'h0004, v);
        check_output("vel_sat_pos", v, 8'h7F);
        do_reset();
        for (int i = 0; i < 200; i++) step_ccw();
        repeat (400) @(negedge clk);
        read_reg(16'h0004, v);
        check_output("vel_sat_neg", v, 8'h80);
`else
        read_reg(16'h0004, v);
        check_output("vel_absent", v, 8'h00);
        for (int i = 0; i < 12; i++) begin
            step_cw();
            repeat (96) @(negedge clk);
        end
        read_reg(16'h0004, v);
        check_output("vel_absent_moving", v, 8'h00);
        read_reg(16'h0003, v);
        check_output("moving_absent", v & 8'h10, 8'h00);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
